bram_port_arbiter: RTL and testbench

//  Shares the single-port frame-buffer BRAM between the capture writer (8-bit samples + address

---
 rtl/bram_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_port_arbiter : single-port BRAM share, read priority + write FIFO     |
// | Optional ARB_OVF_COUNT_EN adds OVF_COUNT (dropped writes).     Rev 1.0     |
// +----------------------------------------------------------------------------+
module bram_port_arbiter #(
  parameter int AW         = 14,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int HI_WM      = 6,
  parameter int LO_WM      = 2
) (
  input  logic          O_CLK,
  input  logic          O_RST_N,
  input  logic          WR_REQ,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [DW-1:0] WR_DATA,
  output logic          WR_FULL,
  input  logic          RD_REQ,
  input  logic [AW-1:0] RD_ADDR,
  output logic          RD_ACK,
  output logic [DW-1:0] RD_DATA,
  output logic          RD_VALID,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DIN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DOUT,
  output logic          OVERFLOW,
`ifdef ARB_OVF_COUNT_EN
  output logic [15:0]   OVF_COUNT,
`endif
  input  logic          OVF_CLR
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] HI_L    = LW'(HI_WM);
  localparam logic [LW-1:0] LO_L    = LW'(LO_WM);

  typedef enum logic [0:0] {NORMAL = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] bram_addr_q, bram_addr_d;
  logic [DW-1:0] bram_din_q, bram_din_d;
  logic          bram_we_q, bram_we_d;
  logic          rd_ack_q, rd_ack_d;
  logic          dout_vld_q, dout_vld_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_full_q, wr_full_d;
  logic          overflow_q, overflow_d;

  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];

  logic grant_rd, pop, push, drop;

  always_comb begin
    grant_rd    = 1'b0;
    pop         = 1'b0;
    state_d     = state_q;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;

    // Grant uses only registered state, so a fresh WR_REQ can never bypass the FIFO.
    if (state_q == NORMAL) begin
      if (RD_REQ)                grant_rd = 1'b1;
      else if (level_q != '0)    pop      = 1'b1;
    end else begin
      if (level_q != '0)         pop      = 1'b1;
      else if (RD_REQ)           grant_rd = 1'b1;
    end

    push = WR_REQ && ((level_q < DEPTH_L) || pop);
    drop = WR_REQ && !push;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    if (state_q == NORMAL) begin
      if (level_d >= HI_L) state_d = FLUSH;
    end else begin
      if (level_d <= LO_L) state_d = NORMAL;
    end

    if (grant_rd) begin
      bram_addr_d = RD_ADDR;
    end else if (pop) begin
      bram_addr_d = fifo_addr_q[rd_ptr_q];
      bram_din_d  = fifo_data_q[rd_ptr_q];
    end
    bram_we_d  = pop;
    rd_ack_d   = grant_rd;

    // BRAM_DOUT is valid the cycle after the read address was presented.
    dout_vld_d = rd_ack_q;
    rd_valid_d = dout_vld_q;
    rd_data_d  = dout_vld_q ? BRAM_DOUT : rd_data_q;

    wr_full_d  = (level_d == DEPTH_L);
    overflow_d = drop ? 1'b1 : (OVF_CLR ? 1'b0 : overflow_q);
  end

  always_ff @(posedge O_CLK) begin
    if (!O_RST_N) begin
      state_q     <= NORMAL;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_we_q   <= 1'b0;
      rd_ack_q    <= 1'b0;
      dout_vld_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_full_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      bram_we_q   <= bram_we_d;
      rd_ack_q    <= rd_ack_d;
      dout_vld_q  <= dout_vld_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_full_q   <= wr_full_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge O_CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= WR_ADDR;
      fifo_data_q[wr_ptr_q] <= WR_DATA;
    end
  end

`ifdef ARB_OVF_COUNT_EN
  logic [15:0] ovf_count_q, ovf_count_d;

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (drop) begin
      if (OVF_CLR)                    ovf_count_d = 16'd1;
      else if (ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
    end else if (OVF_CLR) begin
      ovf_count_d = '0;
    end
  end

  always_ff @(posedge O_CLK) begin
    if (!O_RST_N) ovf_count_q <= '0;
    else          ovf_count_q <= ovf_count_d;
  end

  assign OVF_COUNT = ovf_count_q;
`endif

  assign WR_FULL   = wr_full_q;
  assign RD_ACK    = rd_ack_q;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign BRAM_ADDR = bram_addr_q;
  assign BRAM_DIN  = bram_din_q;
  assign BRAM_WE   = bram_we_q;
  assign OVERFLOW  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bram_port_arbiter : directed self-checking bench for bram_port_arbiter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // Main instance: default watermarks
  logic        wr_req, rd_req, ovf_clr;
  logic [13:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic        wr_full, rd_ack, rd_valid, bram_we, overflow;
  logic [7:0]  rd_data, bram_din, bram_dout;
  logic [13:0] bram_addr;
  // Second instance: watermark above depth so the FIFO can actually fill and drop
  logic        wr_req2, rd_req2, ovf_clr2;
  logic [13:0] wr_addr2, rd_addr2;
  logic [7:0]  wr_data2;
  logic        wr_full2, rd_ack2, rd_valid2, bram_we2, overflow2;
  logic [7:0]  rd_data2, bram_din2;
  logic [7:0]  bram_dout2 = 8'h00;
  logic [13:0] bram_addr2;
`ifdef ARB_OVF_COUNT_EN
  logic [15:0] ovf_count1, ovf_count2;
`endif

  bram_port_arbiter dut (
    .O_CLK(clk), .O_RST_N(rst_n),
    .WR_REQ(wr_req), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_FULL(wr_full),
    .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_ACK(rd_ack), .RD_DATA(rd_data), .RD_VALID(rd_valid),
    .BRAM_ADDR(bram_addr), .BRAM_DIN(bram_din), .BRAM_WE(bram_we), .BRAM_DOUT(bram_dout),
    .OVERFLOW(overflow),
`ifdef ARB_OVF_COUNT_EN
    .OVF_COUNT(ovf_count1),
`endif
    .OVF_CLR(ovf_clr)
  );

  bram_port_arbiter #(.HI_WM(9), .LO_WM(2)) dut2 (
    .O_CLK(clk), .O_RST_N(rst_n),
    .WR_REQ(wr_req2), .WR_ADDR(wr_addr2), .WR_DATA(wr_data2), .WR_FULL(wr_full2),
    .RD_REQ(rd_req2), .RD_ADDR(rd_addr2), .RD_ACK(rd_ack2), .RD_DATA(rd_data2), .RD_VALID(rd_valid2),
    .BRAM_ADDR(bram_addr2), .BRAM_DIN(bram_din2), .BRAM_WE(bram_we2), .BRAM_DOUT(bram_dout2),
    .OVERFLOW(overflow2),
`ifdef ARB_OVF_COUNT_EN
    .OVF_COUNT(ovf_count2),
`endif
    .OVF_CLR(ovf_clr2)
  );

  // BRAM model with a preload port, plus write logs and a port-clash monitor
  logic [7:0]  mem [0:16383];
  logic        pre_we = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic [13:0] log1 [$];
  logic [13:0] log2 [$];
  logic        clash1 = 1'b0;
  logic        clash2 = 1'b0;

  always @(posedge clk) begin
    if (bram_we)     mem[bram_addr] <= bram_din;
    else if (pre_we) mem[pre_addr]  <= pre_data;
    bram_dout <= mem[bram_addr];
    if (bram_we)  log1.push_back(bram_addr);
    if (bram_we2) log2.push_back(bram_addr2);
    if (bram_we && rd_ack)   clash1 <= 1'b1;
    if (bram_we2 && rd_ack2) clash2 <= 1'b1;
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  base;
  logic exp_ack;

  initial begin
    rst_n = 1'b0;
    wr_req = 0; rd_req = 0; ovf_clr = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    wr_req2 = 0; rd_req2 = 0; ovf_clr2 = 0; wr_addr2 = '0; rd_addr2 = '0; wr_data2 = '0;

    // Reset with requests asserted
    wr_req = 1; rd_req = 1; wr_addr = 14'h03F; rd_addr = 14'h055; wr_data = 8'h11;
    wr_req2 = 1; rd_req2 = 1;
    step(); step();
    chk("rst_bram_we", bram_we, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_bram_din", bram_din, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", dut.level_q, 0);
    chk("rst_bram_we2", bram_we2, 0);
    wr_req = 0; rd_req = 0; wr_req2 = 0; rd_req2 = 0;
    rst_n = 1;
    step();

    // Writes only: WE appears two cycles after the first request, in order
    base = log1.size();
    for (int i = 0; i < 4; i++) begin
      wr_req = 1; wr_addr = 14'(i); wr_data = 8'hA0 + 8'(i);
      step();
      if (i == 0) begin
        chk("wr_no_bypass", bram_we, 0);
      end else begin
        chk("wr_we", bram_we, 1);
        chk("wr_addr", bram_addr, 32'(i - 1));
        chk("wr_din", bram_din, 32'(8'hA0 + 8'(i - 1)));
      end
    end
    wr_req = 0;
    step();
    chk("wr_last_addr", bram_addr, 3);
    chk("wr_last_din", bram_din, 8'hA3);
    chk("wr_level_empty", dut.level_q, 0);
    step();
    chk("wr_idle_we", bram_we, 0);
    chk("wr_idle_addr_hold", bram_addr, 3);
    chk("wr_log_count", 32'(log1.size() - base), 4);
    for (int i = 0; i < 4; i++) chk("wr_log_addr", log1[base + i], 32'(i));
    chk("wr_overflow", overflow, 0);

    // Read latency
    pre_we = 1; pre_addr = 14'h123; pre_data = 8'h5A;
    step();
    pre_we = 0;
    rd_req = 1; rd_addr = 14'h123;
    step();
    chk("rd_ack_t1", rd_ack, 1);
    chk("rd_bram_addr", bram_addr, 14'h123);
    chk("rd_we_t1", bram_we, 0);
    chk("rd_valid_t1", rd_valid, 0);
    rd_req = 0;
    step();
    chk("rd_ack_t2", rd_ack, 0);
    chk("rd_valid_t2", rd_valid, 0);
    step();
    chk("rd_valid_t3", rd_valid, 1);
    chk("rd_data_t3", rd_data, 8'h5A);
    step();
    chk("rd_valid_t4", rd_valid, 0);

    // Watermark: 8 writes under continuous reads
    base = log1.size();
    rd_req = 1; rd_addr = 14'h010;
    for (int k = 0; k < 13; k++) begin
      wr_req = (k < 8); wr_addr = 14'h100 + 14'(k); wr_data = 8'(k);
      step();
      exp_ack = ((k + 1) <= 6) || ((k + 1) >= 13);
      chk("wm_rd_ack", rd_ack, exp_ack);
      chk("wm_bram_we", bram_we, !exp_ack);
      if (k + 1 == 6) begin
        chk("wm_level_hi", dut.level_q, 6);
        chk("wm_state_flush", 32'(dut.state_q), 1);
      end
      if (k + 1 == 12) chk("wm_level_lo", dut.level_q, 2);
    end
    rd_req = 0; wr_req = 0;
    step(); step(); step(); step();
    chk("wm_level_drained", dut.level_q, 0);
    chk("wm_overflow", overflow, 0);
    chk("wm_log_count", 32'(log1.size() - base), 8);
    for (int i = 0; i < 8; i++) chk("wm_log_addr", log1[base + i], 32'(14'h100 + 14'(i)));

    // Overflow on the second instance: fill under reads, two samples dropped
    base = log2.size();
    rd_req2 = 1; rd_addr2 = 14'h020;
    for (int k = 0; k < 10; k++) begin
      wr_req2 = 1; wr_addr2 = 14'h200 + 14'(k); wr_data2 = 8'(k);
      step();
      chk("ovf_wr_full", wr_full2, ((k + 1) >= 8));
      chk("ovf_overflow", overflow2, ((k + 1) >= 9));
    end
    wr_req2 = 0; rd_req2 = 0;
    step();
    chk("ovf_full_clear", wr_full2, 0);
    chk("ovf_sticky", overflow2, 1);
    chk("ovf_first_we", bram_we2, 1);
    chk("ovf_first_addr", bram_addr2, 14'h200);
    repeat (8) step();
    chk("ovf_log_count", 32'(log2.size() - base), 8);
    for (int i = 0; i < 8; i++) chk("ovf_log_addr", log2[base + i], 32'(14'h200 + 14'(i)));
    chk("ovf_level_drained", dut2.level_q, 0);
    chk("ovf_still_set", overflow2, 1);
`ifdef ARB_OVF_COUNT_EN
    chk("ovf_count", ovf_count2, 2);
`endif
    ovf_clr2 = 1;
    step();
    ovf_clr2 = 0;
    chk("ovf_cleared", overflow2, 0);
`ifdef ARB_OVF_COUNT_EN
    chk("ovf_count_cleared", ovf_count2, 0);
`endif

    // Mid-operation reset with three entries queued and reads in flight
    rd_addr = 14'h040;
    for (int k = 0; k < 4; k++) begin
      rd_req = 1; wr_req = (k < 3); wr_addr = 14'h300 + 14'(k); wr_data = 8'h30 + 8'(k);
      step();
    end
    wr_req = 0;
    chk("mid_rd_ack", rd_ack, 1);
    chk("mid_level", dut.level_q, 3);
    base = log1.size();
    rst_n = 0; rd_req = 0;
    step();
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_ack", rd_ack, 0);
    chk("mid_rst_we", bram_we, 0);
    chk("mid_rst_level", dut.level_q, 0);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_post_valid", rd_valid, 0);
      chk("mid_post_we", bram_we, 0);
    end
    chk("mid_no_writes", 32'(log1.size() - base), 0);

    chk("no_clash_dut", clash1, 0);
    chk("no_clash_dut2", clash2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
